// File: rtl/text_console_ctrl.sv
// Write-port sequencer for the COLS x ROWS character buffer: accepts ASCII keys,
// tracks the cursor, and runs multi-cycle scroll and clear passes over the buffer.
module text_console_ctrl #(
  parameter int COLS = 70,
  parameter int ROWS = 30,
  parameter int AW   = 12
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          key_valid,
  input  logic [7:0]    key_ascii,
  output logic          key_ready,
  input  logic          clr,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic [6:0]    cursor_col,
  output logic [4:0]    cursor_row,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    SCR_RD,
    SCR_WR,
    SCR_CLR,
    CLEAR
  } state_t;

  localparam logic [AW-1:0] COLS_A        = AW'(COLS);
  localparam logic [AW-1:0] SCROLL_LAST   = AW'(COLS * (ROWS - 1) - 1);
  localparam logic [AW-1:0] LAST_ROW_BASE = AW'(COLS * (ROWS - 1));
  localparam logic [AW-1:0] SCREEN_LAST   = AW'(COLS * ROWS - 1);
  localparam logic [6:0]    COL_MAX       = 7'(COLS - 1);
  localparam logic [4:0]    ROW_MAX       = 5'(ROWS - 1);
  localparam logic [7:0]    SPACE         = 8'h20;

  state_t          state_q, state_d;
  logic [6:0]      col_q;
  logic [4:0]      row_q;
  logic [7:0]      code_q;
  logic [AW-1:0]   idx_q;

  logic            is_print, is_nl, is_bs;
  logic            at_last_col, at_last_row, at_home;
  logic            scroll_go;
  logic [AW-1:0]   cur_addr;

  assign is_print    = (code_q >= 8'h20) && (code_q <= 8'h7E);
  assign is_nl       = (code_q == 8'h0A) || (code_q == 8'h0D);
  assign is_bs       = (code_q == 8'h08);
  assign at_last_col = (col_q == COL_MAX);
  assign at_last_row = (row_q == ROW_MAX);
  assign at_home     = (col_q == 7'd0) && (row_q == 5'd0);
  assign scroll_go   = at_last_row && ((is_print && at_last_col) || is_nl);
  // Backspace target is always cur_addr-1: at col 0 that is the last cell of the previous row.
  assign cur_addr    = AW'(row_q) * COLS_A + AW'(col_q);

  assign cursor_col  = col_q;
  assign cursor_row  = row_q;
  assign busy        = (state_q != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    key_ready = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        key_ready = !clr;
        if (clr)            state_d = CLEAR;
        else if (key_valid) state_d = EXEC;
      end
      EXEC: begin
        state_d = scroll_go ? SCR_RD : IDLE;
        if (is_print) begin
          mem_we    = 1'b1;
          mem_addr  = cur_addr;
          mem_wdata = code_q;
        end else if (is_bs && !at_home) begin
          mem_we    = 1'b1;
          mem_addr  = cur_addr - AW'(1);
          mem_wdata = SPACE;
        end
      end
      SCR_RD: begin
        mem_addr = idx_q + COLS_A;
        state_d  = SCR_WR;
      end
      SCR_WR: begin
        mem_we    = 1'b1;
        mem_addr  = idx_q;
        mem_wdata = mem_rdata;
        state_d   = (idx_q == SCROLL_LAST) ? SCR_CLR : SCR_RD;
      end
      SCR_CLR, CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = idx_q;
        mem_wdata = SPACE;
        if (idx_q == SCREEN_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q  <= '0;
      row_q  <= '0;
      code_q <= '0;
      idx_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clr) begin
            col_q <= '0;
            row_q <= '0;
            idx_q <= '0;
          end else if (key_valid) begin
            code_q <= key_ascii;
          end
        end
        EXEC: begin
          idx_q <= '0;
          if (is_print) begin
            if (!at_last_col) begin
              col_q <= col_q + 7'd1;
            end else begin
              col_q <= '0;
              if (!at_last_row) row_q <= row_q + 5'd1;
            end
          end else if (is_nl) begin
            col_q <= '0;
            if (!at_last_row) row_q <= row_q + 5'd1;
          end else if (is_bs) begin
            if (col_q != 7'd0) begin
              col_q <= col_q - 7'd1;
            end else if (row_q != 5'd0) begin
              row_q <= row_q - 5'd1;
              col_q <= COL_MAX;
            end
          end
        end
        SCR_WR:         idx_q <= (idx_q == SCROLL_LAST) ? LAST_ROW_BASE : idx_q + AW'(1);
        SCR_CLR, CLEAR: idx_q <= idx_q + AW'(1);
        default: ;
      endcase
    end
  end

endmodule
